// File: rtl/iic_reg_slave_if.sv
// Register-bank side of the IIC register slave: the 16-byte configuration bank
// and the per-byte write notification.
interface iic_reg_slave_if;
    logic [127:0] cfg_data;
    logic         wr_strobe;
    logic [3:0]   wr_addr;

    modport slave  (output cfg_data, output wr_strobe, output wr_addr);
    modport master (input  cfg_data, input  wr_strobe, input  wr_addr);
endinterface

// File: rtl/iic_reg_slave.sv
// IIC target exposing a 16-byte register bank with an auto-incrementing pointer.
// SCL is only observed; SDA is open-drain (pulled low or released).
module iic_reg_slave #(
    parameter logic [6:0] IIC_ADDR = 7'h50
) (
    input  logic          aclk,
    input  logic          areset,
    inout  wire  [1:0]    iic,
    iic_reg_slave_if.slave bank
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
    } state_e;

    state_e       state_q;
    logic [1:0]   sclSync_q, sdaSync_q;
    logic         sclPrev_q, sdaPrev_q;
    logic [3:0]   bitCnt_q;
    logic [7:0]   shift_q;
    logic [3:0]   ptr_q;
    logic [127:0] cfg_q;
    logic         sdaLow_q;
    logic         wrStrobe_q;
    logic [3:0]   wrAddr_q;

    logic         scl, sda, sclRise, sclFall, startDet, stopDet;
    logic [7:0]   shift_d, bankByte_d;
    logic [3:0]   ptr_d;

    assign scl        = sclSync_q[1];
    assign sda        = sdaSync_q[1];
    assign sclRise    = scl & ~sclPrev_q;
    assign sclFall    = ~scl & sclPrev_q;
    assign startDet   = scl & sclPrev_q & sdaPrev_q & ~sda;
    assign stopDet    = scl & sclPrev_q & ~sdaPrev_q & sda;
    assign shift_d    = {shift_q[6:0], sda};
    assign ptr_d      = ptr_q + 4'd1;
    assign bankByte_d = cfg_q[{ptr_q, 3'b000} +: 8];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[0], iic[0]};
            sdaSync_q <= {sdaSync_q[0], iic[1]};
            sclPrev_q <= sclSync_q[1];
            sdaPrev_q <= sdaSync_q[1];
        end
    end

    // ACK states use sdaLow_q to tell the fall that opens the slot from the one that closes it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 4'd0;
            cfg_q      <= '0;
            sdaLow_q   <= 1'b0;
            wrStrobe_q <= 1'b0;
            wrAddr_q   <= 4'd0;
        end else begin
            wrStrobe_q <= 1'b0;
            if (startDet) begin
                state_q  <= ADDR;
                bitCnt_q <= 4'd0;
                sdaLow_q <= 1'b0;
            end else if (stopDet) begin
                state_q  <= IDLE;
                sdaLow_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    ADDR, PTR, WRITE: begin
                        if (sclRise) begin
                            shift_q  <= shift_d;
                            bitCnt_q <= bitCnt_q + 4'd1;
                            if (bitCnt_q == 4'd7) begin
                                bitCnt_q <= 4'd0;
                                if (state_q == ADDR) begin
                                    if (shift_d[7:1] == IIC_ADDR) state_q <= ADDR_ACK;
                                    else                           state_q <= IDLE;
                                end else if (state_q == PTR) begin
                                    ptr_q   <= shift_d[3:0];
                                    state_q <= PTR_ACK;
                                end else begin
                                    cfg_q[{ptr_q, 3'b000} +: 8] <= shift_d;
                                    wrStrobe_q <= 1'b1;
                                    wrAddr_q   <= ptr_q;
                                    state_q    <= WRITE_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WRITE_ACK: begin
                        if (sclFall) begin
                            if (!sdaLow_q) begin
                                sdaLow_q <= 1'b1;
                            end else begin
                                sdaLow_q <= 1'b0;
                                bitCnt_q <= 4'd0;
                                if (state_q == ADDR_ACK) begin
                                    if (shift_q[0]) begin
                                        state_q  <= READ;
                                        shift_q  <= bankByte_d;
                                        sdaLow_q <= ~bankByte_d[7];
                                    end else begin
                                        state_q <= PTR;
                                    end
                                end else if (state_q == PTR_ACK) begin
                                    state_q <= WRITE;
                                end else begin
                                    ptr_q   <= ptr_d;
                                    state_q <= WRITE;
                                end
                            end
                        end
                    end
                    READ: begin
                        if (sclRise) begin
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end else if (sclFall) begin
                            if (bitCnt_q == 4'd8) begin
                                sdaLow_q <= 1'b0;
                                bitCnt_q <= 4'd0;
                                state_q  <= READ_ACK;
                            end else begin
                                sdaLow_q <= ~shift_q[6];
                                shift_q  <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    READ_ACK: begin
                        // bitCnt_q == 1 marks a master ACK still waiting for its closing fall.
                        if (sclRise) begin
                            if (!sda) begin
                                ptr_q    <= ptr_d;
                                bitCnt_q <= 4'd1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (sclFall && bitCnt_q == 4'd1) begin
                            state_q  <= READ;
                            bitCnt_q <= 4'd0;
                            shift_q  <= bankByte_d;
                            sdaLow_q <= ~bankByte_d[7];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign iic[1]         = sdaLow_q ? 1'b0 : 1'bz;
    assign bank.cfg_data  = cfg_q;
    assign bank.wr_strobe = wrStrobe_q;
    assign bank.wr_addr   = wrAddr_q;
endmodule
